vga_scan_controller: RTL
========================

# vga_scan_controller

Parametrised VGA raster engine: generates HS/VS/blank for any mode from porch/sync parameters, issues linear framebuffer read addresses with optional power-of-two downscaling, and realigns returned pixel data with the sync signals across a configurable memory read latency. It sits between the framebuffer/palette RAMs and the DAC pins, replacing the fixed-640×480 address generator and sync path.

## Interface

- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, active level of oHS (0 = active-low)
- VS_POL, 0, active level of oVS
- SCALE, 0, log2 of pixel replication; framebuffer is (H_ACTIVE>>SCALE)×(V_ACTIVE>>SCALE)
- MEM_LAT, 2, cycles from oADDR change to matching iPIX_DATA (≥1)
- ADDR_W, 19, framebuffer address width
- iVGA_CLK  in  1  pixel clock; the only clock
- iRST  in  1  asynchronous, active-high reset
- oADDR  out  ADDR_W  framebuffer read address
- oADDR_VALID  out  1  high while oADDR refers to a visible pixel
- iPIX_DATA  in  24  {B,G,R} from palette/framebuffer, MEM_LAT cycles after oADDR
- oFRAME_START  out  1  one-cycle pulse with oADDR of pixel (0,0)
- oHS  out  1  horizontal sync, polarity HS_POL
- oVS  out  1  vertical sync, polarity VS_POL
- oBLANK_n  out  1  high during visible pixels
- b_data, g_data, r_data  out  8 each  colour outputs

## Operation

- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H_*), v_cnt 0..V_TOTAL-1; h_cnt wraps to 0 and v_cnt increments on h_cnt = H_TOTAL-1; v_cnt wraps to 0 at V_TOTAL-1 with h wrap.
- Region order per axis: active [0, ACTIVE), front porch, sync [ACTIVE+FP, ACTIVE+FP+SYNC), back porch.
- Visible = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Address: no multiplier. Line-base register, reset to 0 at (0,0); on each line wrap where (v_cnt+1)>>SCALE differs from v_cnt>>SCALE and next line is visible, base += H_ACTIVE>>SCALE. oADDR = base + (h_cnt>>SCALE), truncated to ADDR_W. During non-visible cycles oADDR holds its last value and oADDR_VALID = 0.
- Colour: when the delayed visible flag is high, {b,g,r}_data register iPIX_DATA; otherwise register 0.
- Reset (any time, including mid-line): counters, base, oADDR, oADDR_VALID, oFRAME_START, all colours → 0; oBLANK_n → 0; oHS → !HS_POL, oVS → !VS_POL; every delay-line stage loads the inactive values. First frame after release starts at (0,0).
- Elaboration-time check: H_ACTIVE and V_ACTIVE divisible by 2^SCALE; MEM_LAT ≥ 1; (H_ACTIVE·V_ACTIVE)>>(2·SCALE) ≤ 2^ADDR_W.

## Timing

- Counter state (x,y) in cycle t → oADDR/oADDR_VALID/oFRAME_START in cycle t+1.
- iPIX_DATA for that address sampled at end of cycle t+1+MEM_LAT.
- oHS/oVS/oBLANK_n/colours for (x,y) all appear in cycle t+2+MEM_LAT; total latency L = MEM_LAT+2, identical for all outputs (shift register of depth L for sync/blank/visible).
- Outputs fully registered; no combinational input→output path.

## Structure

- Shared package vga_pkg: H_TOTAL/V_TOTAL computation function, region-boundary localparams, 24-bit BGR pixel typedef and channel slice constants.
- One sub-module: vga_delay_line (parametrised width/depth shift register, async reset to parametrised value), used for sync/blank/visible alignment.

## Test plan

Bench parameters: H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), MEM_LAT 2, SCALE 0, polarities 0; memory model returns address value as pixel data.
- Reset release → oFRAME_START high in cycle 1, oADDR 0; oBLANK_n first high in cycle 4 with r_data = 0x00; line 0 emits addresses 0..7.
- Full frame → oHS low exactly 3 clocks per 16, starting 10 clocks after first oBLANK_n of a line; oVS low for 32 clocks; oFRAME_START period 128 clocks.
- Blanking → colours 0 in every cycle oBLANK_n = 0 even with iPIX_DATA = 0xFFFFFF.
- SCALE = 1 → addresses per line 0,0,1,1,2,2,3,3; lines 0 and 1 both start at 0, lines 2 and 3 at 4.
- HS_POL = VS_POL = 1 → sync pulses high, idle low, including during reset.
- Assert iRST mid-line 2 for 3 cycles → outputs immediately at reset values; after release raster restarts at (0,0) with correct L alignment.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster engine:
//   - default (640x480 @ 60 Hz) timing constants used as parameter defaults
//   - helpers computing line/frame totals and sync-region boundaries
//   - 24-bit {B,G,R} pixel type and the bit positions of each channel
// ---------------------------------------------------------------------------
package vga_pkg;

    // Default mode timing (pixel clocks / lines)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Pixel word as delivered by the palette/framebuffer: {B,G,R}
    typedef logic [23:0] pixel_t;

    localparam int CH_W  = 8;
    localparam int R_LSB = 0;
    localparam int G_LSB = 8;
    localparam int B_LSB = 16;

    // Total clocks per line (or lines per frame) for one axis
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First counter value inside the sync pulse
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // First counter value after the sync pulse
    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// Parametrised WIDTH x DEPTH shift register. din presented in cycle t
// appears on dout in cycle t+DEPTH. Asynchronous reset loads every stage
// with RST_VAL so the output is at its idle level throughout reset.
// Ports:
//   clk   in   shift clock
//   rst   in   asynchronous, active-high reset
//   din   in   WIDTH  data entering the line
//   dout  out  WIDTH  data leaving the line (registered)
// ---------------------------------------------------------------------------
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_controller.sv
// ---------------------------------------------------------------------------
// vga_scan_controller
// Parametrised VGA raster engine. Generates HS/VS/blank from porch/sync
// parameters, issues linear framebuffer read addresses (with optional
// power-of-two pixel replication) and realigns the returned pixel data with
// the sync signals across MEM_LAT cycles of memory read latency.
// All outputs for a counter position appear MEM_LAT+2 cycles after it.
// Ports:
//   iVGA_CLK      in   pixel clock
//   iRST          in   asynchronous, active-high reset
//   oADDR         out  ADDR_W framebuffer read address (held when not visible)
//   oADDR_VALID   out  oADDR refers to a visible pixel
//   iPIX_DATA     in   24 {B,G,R}, MEM_LAT cycles after oADDR
//   oFRAME_START  out  pulse alongside the address of pixel (0,0)
//   oHS, oVS      out  sync outputs, active level HS_POL / VS_POL
//   oBLANK_n      out  high during visible pixels
//   b/g/r_data    out  8-bit colour channels, zero while blanked
// ---------------------------------------------------------------------------
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int SCALE    = 0,
    parameter int MEM_LAT  = 2,
    parameter int ADDR_W   = 19
) (
    input  logic              iVGA_CLK,
    input  logic              iRST,
    output logic [ADDR_W-1:0] oADDR,
    output logic              oADDR_VALID,
    input  logic [23:0]       iPIX_DATA,
    output logic              oFRAME_START,
    output logic              oHS,
    output logic              oVS,
    output logic              oBLANK_n,
    output logic [7:0]        b_data,
    output logic [7:0]        g_data,
    output logic [7:0]        r_data
);

    localparam int H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_W      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int V_W      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int HS_START = sync_start(H_ACTIVE, H_FP);
    localparam int HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
    localparam int VS_START = sync_start(V_ACTIVE, V_FP);
    localparam int VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);
    localparam int LAT      = MEM_LAT + 2;

    localparam logic [H_W-1:0]    H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]    V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE >> SCALE);

    // Configuration sanity checks, evaluated at elaboration
    if ((H_ACTIVE % (1 << SCALE)) != 0 || (V_ACTIVE % (1 << SCALE)) != 0) begin : g_bad_scale
        $error("vga_scan_controller: active area not divisible by 2**SCALE");
    end
    if (MEM_LAT < 1) begin : g_bad_lat
        $error("vga_scan_controller: MEM_LAT must be at least 1");
    end
    if (((longint'(H_ACTIVE) * longint'(V_ACTIVE)) >> (2 * SCALE)) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("vga_scan_controller: framebuffer does not fit in ADDR_W bits");
    end

    // -----------------------------------------------------------------------
    // Raster counters and line base
    // -----------------------------------------------------------------------
    logic [H_W-1:0]    h_cnt_q, h_cnt_d;
    logic [V_W-1:0]    v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_valid_q, addr_valid_d;
    logic              frame_start_q, frame_start_d;

    logic visible_c;
    logic hs_c;
    logic vs_c;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        base_d  = base_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
                base_d  = '0;
            end else begin
                v_cnt_d = v_cnt_q + 1'b1;
                // Advance the base only when the next line is visible and
                // starts a new framebuffer row (replicated lines share one).
                if ((int'(v_cnt_q) + 1 < V_ACTIVE) &&
                    (((int'(v_cnt_q) + 1) >> SCALE) != (int'(v_cnt_q) >> SCALE))) begin
                    base_d = base_q + LINE_STEP;
                end
            end
        end
    end

    always_comb begin
        visible_c     = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
        hs_c          = ((int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_END)) ? HS_POL : ~HS_POL;
        vs_c          = ((int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_END)) ? VS_POL : ~VS_POL;
        addr_valid_d  = visible_c;
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        // Hold the last address outside the visible area to avoid toggling
        // the memory bus during blanking.
        addr_d        = visible_c ? (base_q + ADDR_W'(h_cnt_q >> SCALE)) : addr_q;
    end

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            base_q        <= '0;
            addr_q        <= '0;
            addr_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            base_q        <= base_d;
            addr_q        <= addr_d;
            addr_valid_q  <= addr_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    // -----------------------------------------------------------------------
    // Alignment: sync/blank travel the full latency; the visible flag is one
    // stage shorter because the colour register supplies the final stage.
    // -----------------------------------------------------------------------
    logic [2:0] sync_late;
    logic       vis_late;

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (LAT),
        .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
    ) u_sync_dly (
        .clk  (iVGA_CLK),
        .rst  (iRST),
        .din  ({hs_c, vs_c, visible_c}),
        .dout (sync_late)
    );

    vga_delay_line #(
        .WIDTH   (1),
        .DEPTH   (LAT - 1),
        .RST_VAL (1'b0)
    ) u_vis_dly (
        .clk  (iVGA_CLK),
        .rst  (iRST),
        .din  (visible_c),
        .dout (vis_late)
    );

    pixel_t pix_q, pix_d;

    always_comb begin
        pix_d = vis_late ? iPIX_DATA : '0;
    end

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign oADDR        = addr_q;
    assign oADDR_VALID  = addr_valid_q;
    assign oFRAME_START = frame_start_q;
    assign oHS          = sync_late[2];
    assign oVS          = sync_late[1];
    assign oBLANK_n     = sync_late[0];
    assign r_data       = pix_q[R_LSB +: CH_W];
    assign g_data       = pix_q[G_LSB +: CH_W];
    assign b_data       = pix_q[B_LSB +: CH_W];

endmodule
